// File: rtl/disp_pkg.sv
// Shared encodings and glyph constants for the seven-segment display path.
package disp_pkg;

    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_BPM  = 2'd1,
        SRC_REC  = 2'd2,
        SRC_KEY  = 2'd3
    } src_e;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;

    localparam int SLOTS = 4;

endpackage

// File: rtl/disp_scheduler_glyph_rom.sv
// Hex digit to active-low seven-segment pattern, shared by BPM and keypad digits.
module seg_glyph_rom (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        unique case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/disp_scheduler.sv
// Display scan controller: refresh prescaler, per-frame source arbitration and
// registered anode/segment drive for the 4-digit seven-segment display.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 25000,
    parameter int HOLD_FRAMES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beat,
    input  logic       rec_active,
    input  logic [3:0] bpm_tens,
    input  logic [3:0] bpm_ones,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] anode,
    output logic [6:0] segOut,
    output logic [1:0] src
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [1:0]    nextIdx;
    logic          tick;
    logic          frameEnd;
    logic          beatMeta;
    logic          beatS;
    logic [HW-1:0] hold;
    logic [3:0]    keyR;
    src_e          curSrc;
    src_e          newSrc;
    src_e          frameSrc;
    logic [3:0]    romIn;
    logic [6:0]    romSeg;
    logic [6:0]    segNext;

    assign tick     = (pcnt == PW'(REFRESH_DIV - 1));
    assign nextIdx  = idx + 2'd1;
    assign frameEnd = tick && (idx == 2'(SLOTS - 1));
    assign src      = curSrc;

    always_comb begin
        if (hold != '0)
            newSrc = SRC_KEY;
        else if (beatS)
            newSrc = SRC_BPM;
        else if (rec_active)
            newSrc = SRC_REC;
        else
            newSrc = SRC_IDLE;
    end

    // Digit 0 of a new frame must already use the source chosen at that boundary.
    assign frameSrc = frameEnd ? newSrc : curSrc;
    assign romIn    = (frameSrc == SRC_KEY) ? keyR
                    : (nextIdx == 2'd0)     ? bpm_ones : bpm_tens;

    seg_glyph_rom u_rom (
        .value (romIn),
        .seg   (romSeg)
    );

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        segNext = GLYPH_BLANK;
        unique case (frameSrc)
            SRC_BPM: begin
                if (nextIdx == 2'd0)
                    segNext = (bpm_ones > 4'd9) ? GLYPH_DASH : romSeg;
                else if (nextIdx == 2'd1 && bpm_tens != 4'd0)
                    segNext = (bpm_tens > 4'd9) ? GLYPH_DASH : romSeg;
            end
            SRC_REC: begin
                if (nextIdx == 2'd2)      segNext = GLYPH_R;
                else if (nextIdx == 2'd1) segNext = GLYPH_E;
                else if (nextIdx == 2'd0) segNext = GLYPH_C;
            end
            SRC_KEY: begin
                if (nextIdx == 2'd0) segNext = romSeg;
            end
            SRC_IDLE: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt     <= '0;
            idx      <= 2'd0;
            beatMeta <= 1'b0;
            beatS    <= 1'b0;
        end else begin
            pcnt     <= tick ? '0 : pcnt + PW'(1);
            beatMeta <= beat;
            beatS    <= beatMeta;
            if (tick) idx <= nextIdx;
        end
    end

    // A key press always reloads, even on a boundary, so the echo never shortens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            keyR <= 4'd0;
        end else begin
            if (key_valid) begin
                hold <= HW'(HOLD_FRAMES);
                keyR <= key_code;
            end else if (frameEnd && hold != '0) begin
                hold <= hold - HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curSrc <= SRC_IDLE;
            anode  <= 4'b1111;
            segOut <= GLYPH_BLANK;
        end else if (tick) begin
            curSrc <= frameSrc;
            anode  <= ~(4'b0001 << nextIdx);
            segOut <= segNext;
        end
    end

endmodule

// File: tb/tb_disp_scheduler.sv
// Self-checking bench: per-cycle comparison against a behavioural display model
// plus directed scenarios with literal expectations.
module tb_disp_scheduler;

    localparam int RD = 4;
    localparam int HF = 2;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beat = 1'b0;
    logic       rec_active = 1'b0;
    logic [3:0] bpm_tens = 4'd0;
    logic [3:0] bpm_ones = 4'd0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] anode;
    logic [6:0] segOut;
    logic [1:0] src;

    int errors = 0;
    int checks = 0;

    disp_scheduler #(.REFRESH_DIV(RD), .HOLD_FRAMES(HF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat       (beat),
        .rec_active (rec_active),
        .bpm_tens   (bpm_tens),
        .bpm_ones   (bpm_ones),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .anode      (anode),
        .segOut     (segOut),
        .src        (src)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [6:0] bcdGlyph(input logic [3:0] v);
        return (v > 4'd9) ? 7'h3F : HEX[v];
    endfunction

    function automatic logic [6:0] glyphFor(input int s, input int i,
                                            input logic [3:0] t, input logic [3:0] o,
                                            input logic [3:0] k);
        case (s)
            1: begin
                if (i == 0) return bcdGlyph(o);
                if (i == 1 && t != 4'd0) return bcdGlyph(t);
            end
            2: begin
                if (i == 2) return 7'h2F;
                if (i == 1) return 7'h06;
                if (i == 0) return 7'h46;
            end
            3: if (i == 0) return HEX[k];
            default: ;
        endcase
        return 7'h7F;
    endfunction

    // Behavioural model: cycle count since reset, frame/slot arithmetic, hold in frames.
    int         mCycle = 0;
    int         mSrc = 0;
    int         mHold = 0;
    int         slotNo;
    int         newIdx;
    logic [3:0] mKey = 4'd0;
    logic [1:0] beatHist = 2'b00;
    logic [3:0] expAnode = 4'b1111;
    logic [6:0] expSeg = 7'h7F;
    bit         isTick;
    bit         isBoundary;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCycle = 0; mSrc = 0; mHold = 0; mKey = 4'd0; beatHist = 2'b00;
            expAnode = 4'b1111; expSeg = 7'h7F;
        end else begin
            slotNo     = mCycle / RD;
            isTick     = (mCycle % RD) == RD - 1;
            isBoundary = isTick && (slotNo % 4 == 3);
            if (isTick) begin
                newIdx = (slotNo + 1) % 4;
                if (isBoundary)
                    mSrc = (mHold > 0) ? 3 : beatHist[1] ? 1 : rec_active ? 2 : 0;
                expAnode = ~(4'b0001 << newIdx);
                expSeg   = glyphFor(mSrc, newIdx, bpm_tens, bpm_ones, mKey);
            end
            if (key_valid) begin
                mHold = HF;
                mKey  = key_code;
            end else if (isBoundary && mHold > 0) begin
                mHold--;
            end
            beatHist = {beatHist[0], beat};
            mCycle++;
        end
    end

    always @(negedge clk) begin
        check("model_anode", {12'd0, anode}, {12'd0, expAnode});
        check("model_seg", {9'd0, segOut}, {9'd0, expSeg});
        check("model_src", {14'd0, src}, mSrc[15:0]);
    end

    task automatic waitAnode(input logic [3:0] a, input string nm);
        int n = 0;
        while (anode !== a && n < 100) begin @(negedge clk); n++; end
        check(nm, {12'd0, anode}, {12'd0, a});
    endtask

    task automatic waitSrc(input logic [1:0] s, input string nm);
        int n = 0;
        while (src !== s && n < 200) begin @(negedge clk); n++; end
        check(nm, {14'd0, src}, {14'd0, s});
    endtask

    task automatic pulseKey(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic countKeyCycles(input int pulseAt, output int cnt);
        cnt = 1;
        while (cnt < 200) begin
            @(negedge clk);
            if (src !== 2'd3) break;
            cnt++;
            key_valid = (cnt == pulseAt);
        end
        key_valid = 1'b0;
    endtask

    int  cnt;
    bit  sawKey;

    initial begin
        // Reset and first tick.
        repeat (3) @(negedge clk);
        check("rst_anode", {12'd0, anode}, 16'h000F);
        check("rst_seg", {9'd0, segOut}, 16'h007F);
        check("rst_src", {14'd0, src}, 16'h0000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_tick_anode", {12'd0, anode}, 16'h000F);
        @(negedge clk);
        check("first_tick_anode", {12'd0, anode}, 16'h000D);
        check("first_tick_seg", {9'd0, segOut}, 16'h007F);

        // BPM 12.
        beat = 1'b1; bpm_tens = 4'd1; bpm_ones = 4'd2;
        waitSrc(2'd1, "bpm_src");
        waitAnode(4'b1110, "bpm_a0"); check("bpm_d0", {9'd0, segOut}, 16'h0024);
        waitAnode(4'b1101, "bpm_a1"); check("bpm_d1", {9'd0, segOut}, 16'h0079);
        waitAnode(4'b1011, "bpm_a2"); check("bpm_d2", {9'd0, segOut}, 16'h007F);
        waitAnode(4'b0111, "bpm_a3"); check("bpm_d3", {9'd0, segOut}, 16'h007F);

        // rEC banner, then mid-frame beat has no effect until the boundary.
        beat = 1'b0; rec_active = 1'b1;
        waitSrc(2'd2, "rec_src");
        waitAnode(4'b1110, "rec_a0"); check("rec_d0", {9'd0, segOut}, 16'h0046);
        waitAnode(4'b1101, "rec_a1"); check("rec_d1", {9'd0, segOut}, 16'h0006);
        beat = 1'b1;
        waitAnode(4'b1011, "rec_a2"); check("rec_d2", {9'd0, segOut}, 16'h002F);
        check("rec_hold_src", {14'd0, src}, 16'h0002);
        waitAnode(4'b0111, "rec_a3"); check("rec_d3", {9'd0, segOut}, 16'h007F);
        check("rec_hold_src2", {14'd0, src}, 16'h0002);
        waitSrc(2'd1, "rec_to_bpm");
        check("rec_to_bpm_anode", {12'd0, anode}, 16'h000E);
        rec_active = 1'b0;

        // Keypad echo: exactly two frames, then extended by a retrigger.
        pulseKey(4'hA);
        waitSrc(2'd3, "key_src");
        check("key_anode", {12'd0, anode}, 16'h000E);
        check("key_d0", {9'd0, segOut}, 16'h0008);
        countKeyCycles(0, cnt);
        check("key_len", cnt[15:0], 16'd32);
        check("key_back_bpm", {14'd0, src}, 16'h0001);
        pulseKey(4'h5);
        waitSrc(2'd3, "key2_src");
        countKeyCycles(20, cnt);
        check("key_ext_len", cnt[15:0], 16'd64);

        // BPM leading-zero suppression and out-of-range dash.
        bpm_tens = 4'd0; bpm_ones = 4'd7;
        waitAnode(4'b0111, "lz_sync");
        waitAnode(4'b1110, "lz_a0"); check("lz_d0", {9'd0, segOut}, 16'h0078);
        waitAnode(4'b1101, "lz_a1"); check("lz_d1", {9'd0, segOut}, 16'h007F);
        bpm_ones = 4'hB;
        waitAnode(4'b0111, "dash_sync");
        waitAnode(4'b1110, "dash_a0"); check("dash_d0", {9'd0, segOut}, 16'h003F);

        // Asynchronous reset mid-frame while the echo has one frame left.
        pulseKey(4'h3);
        waitSrc(2'd3, "ar_key_src");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_anode", {12'd0, anode}, 16'h000F);
        check("ar_seg", {9'd0, segOut}, 16'h007F);
        check("ar_src", {14'd0, src}, 16'h0000);
        #4 rst_n = 1'b1;
        sawKey = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (src === 2'd3) sawKey = 1'b1;
        end
        check("ar_no_key", {15'd0, sawKey}, 16'h0000);
        waitSrc(2'd1, "ar_bpm");

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) beat = ~beat;
            if ($urandom_range(0, 29) == 0) rec_active = ~rec_active;
            if ($urandom_range(0, 39) == 0) bpm_tens = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) bpm_ones = 4'($urandom_range(0, 15));
            key_valid = ($urandom_range(0, 149) == 0);
            if (key_valid) key_code = 4'($urandom_range(0, 15));
        end
        key_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Scan controller and source arbiter for the 4-digit seven-segment display in the metronome/recorder design. It time-multiplexes the anodes from a programmable refresh prescaler. It selects one display source per refresh frame: keypad echo, tempo (BPM) digits, "rEC" banner, or blank. It then drives registered active-low anode and segment outputs. It sits between the tempo/record/keypad logic and the board pins, so the display path is tear-free and fully synchronous.

## Interface
Parameters:
- REFRESH_DIV, 25000, clock cycles per digit slot (≥2); 100 MHz gives a 4 kHz slot rate and a 1 kHz frame rate.
- HOLD_FRAMES, 1024, number of frames a keypad echo stays on the display after the last key.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- beat  in  1  metronome beat level, asynchronous to clk; BPM is shown while high.
- rec_active  in  1  recording in progress; synchronous.
- bpm_tens  in  4  BCD tens digit of tempo.
- bpm_ones  in  4  BCD ones digit of tempo.
- key_valid  in  1  one-cycle strobe: new key pressed.
- key_code  in  4  hex key value, qualified by key_valid.
- anode  out  4  active-low digit enables; bit0 is the rightmost digit.
- segOut  out  7  active-low cathodes {g,f,e,d,c,b,a}.
- src  out  2  source currently displayed (debug/verification).

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when pcnt == REFRESH_DIV-1.
- Digit index `idx` advances on each tick: 0→1→2→3→0.
- A frame boundary is a tick with idx == 3.
- `beat` passes through a 2-flop synchronizer to give `beat_s`. All other inputs are synchronous.
- Key capture: key_valid latches key_code into `key_r` and loads `hold` = HOLD_FRAMES.
- `hold` decrements by 1 at each frame boundary while nonzero.
- A key_valid in the same cycle as a frame boundary reloads `hold` with no decrement. Retrigger always reloads.
- Arbitration happens only at frame boundaries, and the selected source is held for the whole frame. Priority, highest first:
  - KEY: hold ≠ 0.
  - BPM: beat_s = 1.
  - REC: rec_active = 1.
  - IDLE: otherwise.
- src encoding: IDLE=0, BPM=1, REC=2, KEY=3.
- Digit content per source (any digit not listed is blank, 7'b1111111):
  - BPM: idx0 = glyph(bpm_ones). idx1 = glyph(bpm_tens), but blank if bpm_tens == 0 (leading-zero suppression). Any BCD value > 9 shows dash 7'b0111111.
  - REC: idx2 'r' 7'b0101111; idx1 'E' 7'b0000110; idx0 'C' 7'b1000110.
  - KEY: idx0 = hex glyph(key_r), covering 0–F.
  - IDLE: all digits blank.
- anode = ~(4'b0001 << idx), registered together with segOut so the two never disagree.

## Timing
- Reset values (immediate on rst_n low, asynchronous): anode = 4'b1111, segOut = 7'b1111111, src = 0, idx = 0, pcnt = 0, hold = 0, key_r = 0, synchronizer flops = 0.
- After reset release, anode and segOut stay at their reset values until the first tick. At that tick they load slot idx=1 on the next clock edge.
- Outputs update on the clock edge following `tick`, giving exactly one cycle of latency from tick. Between ticks the outputs are stable.
- The first frame after reset displays IDLE, because the source changes only at a frame boundary.
- Source-change latency: a change in beat_s, rec_active, or hold becomes visible starting at the next frame boundary. For `beat`, add 2 synchronizer cycles.
- key_valid → KEY is shown from the next frame boundary. The echo persists for exactly HOLD_FRAMES frames after the last reload.
- Input changes mid-frame never alter the digits of the current frame: the source is latched per frame, and digit values are sampled at each tick.

## Structure
- Shared include `disp_pkg`:
  - SRC_* encodings.
  - Glyph constants GLYPH_BLANK, GLYPH_DASH, GLYPH_R, GLYPH_E, GLYPH_C.
  - Slot count localparam (4).
- One sub-module, `seg_glyph_rom`: combinational map from 4-bit hex value to 7-bit active-low pattern covering 0–F. It is reused for both BPM and KEY digits; BPM adds the >9 dash override outside the ROM.
- Everything else lives in the top level: prescaler, idx counter, synchronizer, hold counter, arbiter, output registers.

## Test plan
Sim parameters: REFRESH_DIV=4, HOLD_FRAMES=2.
- Reset: rst_n low with clk running → anode=1111, segOut=1111111, src=0. After release, the first output change comes 4 cycles later: anode=1101, still blank.
- BPM: beat=1, tens=1, ones=2; after 2 frames → src=1; anode 1110 → 0100100; anode 1101 → 1111001; anodes 1011 and 0111 → 1111111.
- REC: beat=0, rec_active=1 → src=2; anode 1110 → 1000110, 1101 → 0000110, 1011 → 0101111, 0111 → blank. Setting beat=1 mid-frame causes no change until the next boundary, when src becomes 1.
- KEY: beat=1, one-cycle key_valid with key_code=A → src=3 from the next boundary; anode 1110 → 0001000. src returns to 1 after 2 frames. A second key_valid during the hold extends it by 2 more frames.
- BPM edge cases: tens=0, ones=7 → digit1 blank, digit0 = 1111000. ones=4'hB → digit0 = 0111111.
- Async reset mid-frame: with src=3 and hold=1, pulse rst_n low for a half cycle → all outputs return to reset values immediately, without waiting for a clock edge, and hold is cleared (no KEY afterward).
